// File: rtl/axi_ic_pkg.sv
// Shared AXI interconnect types: default widths, W-steer order entry and a one-hot check.
package axi_ic_pkg;

  localparam int AXI_WIDTH_ID   = 4;
  localparam int AXI_WIDTH_DATA = 32;
  localparam int AXI_NUM_SLV    = 2;
  localparam int AXI_SLV_MAX    = 16;

  typedef struct packed {
    logic [AXI_NUM_SLV-1:0]  sel;
    logic [AXI_WIDTH_ID-1:0] id;
  } wsteer_entry_t;

  // Callers zero-extend narrower select vectors to AXI_SLV_MAX bits.
  function automatic logic is_onehot(input logic [AXI_SLV_MAX-1:0] v);
    logic [AXI_SLV_MAX-1:0] one;
    one = {{(AXI_SLV_MAX-1){1'b0}}, 1'b1};
    return (v != '0) && ((v & (v - one)) == '0);
  endfunction

endpackage

// File: rtl/axi_wdata_steer_if.sv
// Master-side AW/W and slave-side W signals of the write-data steering stage.
// M_AWLEN exists only when AXI_WSTEER_BEATCNT_EN is defined.
interface axi_wdata_steer_if #(
  parameter int NUM_SLV    = 2,
  parameter int WIDTH_ID   = 4,
  parameter int WIDTH_DATA = 32
);
  logic [WIDTH_ID-1:0]     M_AWID;
  logic [NUM_SLV-1:0]      M_AWSEL;
  logic                    M_AWVALID;
  logic                    M_AWREADY;
`ifdef AXI_WSTEER_BEATCNT_EN
  logic [7:0]              M_AWLEN;
`endif
  logic                    AW_BLOCK;
  logic [WIDTH_ID-1:0]     M_WID;
  logic [WIDTH_DATA-1:0]   M_WDATA;
  logic [WIDTH_DATA/8-1:0] M_WSTRB;
  logic                    M_WLAST;
  logic                    M_WVALID;
  logic                    M_WREADY;
  logic [WIDTH_ID-1:0]     S_WID;
  logic [WIDTH_DATA-1:0]   S_WDATA;
  logic [WIDTH_DATA/8-1:0] S_WSTRB;
  logic                    S_WLAST;
  logic [NUM_SLV-1:0]      S_WVALID;
  logic [NUM_SLV-1:0]      S_WREADY;
  logic                    ERR;

  modport slave (
`ifdef AXI_WSTEER_BEATCNT_EN
    input  M_AWLEN,
`endif
    input  M_AWID, M_AWSEL, M_AWVALID, M_AWREADY,
    input  M_WDATA, M_WSTRB, M_WLAST, M_WVALID, S_WREADY,
    output AW_BLOCK, M_WID, M_WREADY,
    output S_WID, S_WDATA, S_WSTRB, S_WLAST, S_WVALID, ERR
  );

  modport master (
`ifdef AXI_WSTEER_BEATCNT_EN
    output M_AWLEN,
`endif
    output M_AWID, M_AWSEL, M_AWVALID, M_AWREADY,
    output M_WDATA, M_WSTRB, M_WLAST, M_WVALID, S_WREADY,
    input  AW_BLOCK, M_WID, M_WREADY,
    input  S_WID, S_WDATA, S_WSTRB, S_WLAST, S_WVALID, ERR
  );
endinterface

// File: rtl/axi_wsteer_fifo_sync.sv
// Synchronous order FIFO with first-word-visible read data and registered count/full.
module axi_wsteer_fifo_sync #(
  parameter int WIDTH = 8,
  parameter int FAW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [FAW:0]     count
);
  localparam int DEPTH = 2**FAW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [FAW-1:0]   wr_ptr;
  logic [FAW-1:0]   rd_ptr;
  logic [FAW:0]     count_nxt;
  logic             push_eff;
  logic             pop_eff;

  // A push into a full FIFO is dropped even if a pop happens in the same cycle.
  assign push_eff = push & ~full;
  assign pop_eff  = pop & ~empty;
  assign empty    = (count == '0);
  assign rdata    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push_eff && !pop_eff)
      count_nxt = count + (FAW+1)'(1);
    else if (pop_eff && !push_eff)
      count_nxt = count - (FAW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push_eff)
      mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push_eff)
        wr_ptr <= wr_ptr + FAW'(1);
      if (pop_eff)
        rd_ptr <= rd_ptr + FAW'(1);
      count <= count_nxt;
      full  <= (count_nxt == (FAW+1)'(DEPTH));
    end
  end

endmodule

// File: rtl/axi_wdata_steer.sv
// Per-master W steering: records AW targets in order and routes W beats until WLAST.
// Optional AXI_WSTEER_BEATCNT_EN adds M_AWLEN and a WLAST position check.
module axi_wdata_steer
  import axi_ic_pkg::*;
#(
  parameter int NUM_SLV    = AXI_NUM_SLV,
  parameter int WIDTH_ID   = AXI_WIDTH_ID,
  parameter int WIDTH_DATA = AXI_WIDTH_DATA,
  parameter int FAW        = 4
) (
  input  logic               ACLK,
  input  logic               ARESET,
  axi_wdata_steer_if.slave   bus
);
`ifdef AXI_WSTEER_BEATCNT_EN
  localparam int ENT_W = 8 + NUM_SLV + WIDTH_ID;
`else
  localparam int ENT_W = NUM_SLV + WIDTH_ID;
`endif

  logic [ENT_W-1:0]    fifo_wdata;
  logic [ENT_W-1:0]    fifo_rdata;
  logic                fifo_full;
  logic                fifo_empty;
  logic [FAW:0]        fifo_count;
  logic                fifo_push;
  logic                fifo_pop;

  logic                aw_hs;
  logic                w_hs;
  logic                wlast_hs;
  logic                head_vld;
  logic [NUM_SLV-1:0]  head_sel;
  logic [WIDTH_ID-1:0] head_id;
  logic                err_set;
  logic                err_q;

  assign aw_hs    = bus.M_AWVALID & bus.M_AWREADY;
  assign w_hs     = bus.M_WVALID & bus.M_WREADY;
  assign wlast_hs = w_hs & bus.M_WLAST;

`ifdef AXI_WSTEER_BEATCNT_EN
  logic [7:0] head_len;
  logic [7:0] beat_q;
  assign fifo_wdata = {bus.M_AWLEN, bus.M_AWSEL, bus.M_AWID};
`else
  assign fifo_wdata = {bus.M_AWSEL, bus.M_AWID};
`endif

  // Empty FIFO with an AW handshake: the new burst is the head in the same cycle.
  always_comb begin
    head_vld = ~fifo_empty | aw_hs;
    head_sel = fifo_rdata[WIDTH_ID +: NUM_SLV];
    head_id  = fifo_rdata[WIDTH_ID-1:0];
`ifdef AXI_WSTEER_BEATCNT_EN
    head_len = fifo_rdata[ENT_W-1 -: 8];
`endif
    if (fifo_empty && aw_hs) begin
      head_sel = bus.M_AWSEL;
      head_id  = bus.M_AWID;
`ifdef AXI_WSTEER_BEATCNT_EN
      head_len = bus.M_AWLEN;
`endif
    end
  end

  // A bypassed burst that completes in its own AW cycle never needs an entry.
  assign fifo_push = aw_hs & ~(fifo_empty & wlast_hs);
  assign fifo_pop  = wlast_hs & (fifo_count != '0);

  axi_wsteer_fifo_sync #(
    .WIDTH (ENT_W),
    .FAW   (FAW)
  ) u_fifo (
    .clk   (ACLK),
    .rst   (ARESET),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.S_WVALID = head_vld ? (head_sel & {NUM_SLV{bus.M_WVALID}}) : '0;
  assign bus.M_WREADY = head_vld & (|(head_sel & bus.S_WREADY));
  assign bus.M_WID    = head_id;
  assign bus.S_WID    = head_id;
  assign bus.S_WDATA  = bus.M_WDATA;
  assign bus.S_WSTRB  = bus.M_WSTRB;
  assign bus.S_WLAST  = bus.M_WLAST;
  assign bus.AW_BLOCK = fifo_full;
  assign bus.ERR      = err_q;

`ifdef AXI_WSTEER_BEATCNT_EN
  always_ff @(posedge ACLK) begin
    if (ARESET)
      beat_q <= '0;
    else if (w_hs)
      beat_q <= bus.M_WLAST ? 8'd0 : beat_q + 8'd1;
  end

  assign err_set = (aw_hs & fifo_full)
                 | (head_vld & ~is_onehot(AXI_SLV_MAX'(head_sel)))
                 | (w_hs & (bus.M_WLAST != (beat_q == head_len)));
`else
  assign err_set = (aw_hs & fifo_full)
                 | (head_vld & ~is_onehot(AXI_SLV_MAX'(head_sel)));
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET)
      err_q <= 1'b0;
    else if (err_set)
      err_q <= 1'b1;
  end

endmodule

// File: tb/tb_axi_wdata_steer.sv
// Directed plus random bench for axi_wdata_steer (depth-4 order FIFO), queue-based reference.
module tb_axi_wdata_steer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_wdata_steer_if #(.NUM_SLV(2), .WIDTH_ID(4), .WIDTH_DATA(32)) bus ();

  axi_wdata_steer #(
    .NUM_SLV    (2),
    .WIDTH_ID   (4),
    .WIDTH_DATA (32),
    .FAW        (2)
  ) dut (
    .ACLK   (clk),
    .ARESET (rst),
    .bus    (bus)
  );

  int   n_vec = 0;
  int   n_err = 0;
  logic [5:0] q [$];   // {sel, id} of recorded bursts, oldest first
  bit   err_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_aw(input bit v, input logic [3:0] id, input logic [1:0] sel);
    bus.M_AWVALID = v;
    bus.M_AWREADY = v;
    bus.M_AWID    = id;
    bus.M_AWSEL   = sel;
  endtask

  task automatic drive_w(input bit v, input bit last, input logic [1:0] srdy);
    bus.M_WVALID = v;
    bus.M_WLAST  = last;
    bus.S_WREADY = srdy;
    bus.M_WDATA  = $urandom;
    bus.M_WSTRB  = 4'($urandom_range(0, 15));
  endtask

  // One clock: check combinational outputs against the model, clock, update model, check state.
  task automatic step();
    logic [1:0] hsel;
    logic [3:0] hid;
    logic [1:0] exp_sv;
    bit aw_hs, hv, exp_rdy, w_hs, bypass_done, do_push;
    #2;
    aw_hs = bus.M_AWVALID && bus.M_AWREADY;
    hv    = (q.size() > 0) || aw_hs;
    if (q.size() > 0) {hsel, hid} = q[0];
    else              {hsel, hid} = {bus.M_AWSEL, bus.M_AWID};
    exp_sv  = hv ? (hsel & {2{bus.M_WVALID}}) : 2'b00;
    exp_rdy = hv && ((hsel & bus.S_WREADY) != 2'b00);
    chk("s_wvalid", bus.S_WVALID, exp_sv);
    chk("m_wready", bus.M_WREADY, exp_rdy);
    chk("s_wdata",  bus.S_WDATA,  bus.M_WDATA);
    chk("s_wstrb",  bus.S_WSTRB,  bus.M_WSTRB);
    chk("s_wlast",  bus.S_WLAST,  bus.M_WLAST);
    if (hv) begin
      chk("m_wid", bus.M_WID, hid);
      chk("s_wid", bus.S_WID, hid);
    end
    w_hs = bus.M_WVALID && exp_rdy;
    @(posedge clk);
    if (rst) begin
      q.delete();
      err_m = 1'b0;
    end else begin
      bypass_done = (q.size() == 0) && aw_hs && w_hs && bus.M_WLAST;
      if (hv && $countones(hsel) != 1) err_m = 1'b1;
      do_push = 1'b0;
      if (aw_hs && !bypass_done) begin
        if (q.size() == DEPTH) err_m = 1'b1;
        else                   do_push = 1'b1;
      end
      if (w_hs && bus.M_WLAST && q.size() > 0) void'(q.pop_front());
      if (do_push) q.push_back({bus.M_AWSEL, bus.M_AWID});
    end
    #1;
    chk("aw_block", bus.AW_BLOCK, q.size() == DEPTH);
    chk("err",      bus.ERR,      err_m);
    chk("count",    dut.u_fifo.count, q.size());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_aw(0, 4'd0, 2'b00);
    drive_w(0, 0, 2'b00);
    step();
    rst = 1'b0;
  endtask

  initial begin
`ifdef AXI_WSTEER_BEATCNT_EN
    bus.M_AWLEN = '0;
`endif
    rst = 1'b1;
    drive_aw(0, 4'd0, 2'b00);
    drive_w(0, 0, 2'b00);
    step();
    step();
    rst = 1'b0;
    drive_w(1, 1, 2'b11);
    step();                                   // no head: W must stall

    drive_aw(1, 4'd3, 2'b10);                 // bypass: AW and single-beat W together
    drive_w(1, 1, 2'b10);
    step();
    drive_aw(0, 4'd0, 2'b00);
    drive_w(0, 0, 2'b00);
    step();

    drive_aw(1, 4'd1, 2'b01);                 // ordering: two AWs, then eight beats
    step();
    drive_aw(1, 4'd2, 2'b10);
    step();
    drive_aw(0, 4'd0, 2'b00);
    for (int i = 0; i < 8; i++) begin
      drive_w(1, (i == 3) || (i == 7), 2'b11);
      step();
    end

    drive_w(0, 0, 2'b00);                     // backpressure on slave 1
    drive_aw(1, 4'd5, 2'b10);
    step();
    drive_aw(0, 4'd0, 2'b00);
    for (int i = 0; i < 5; i++) begin
      drive_w(1, 1, 2'b01);
      step();
    end
    drive_w(1, 1, 2'b11);
    step();

    drive_w(0, 0, 2'b00);                     // simultaneous push and pop
    drive_aw(1, 4'd6, 2'b01);
    step();
    drive_aw(1, 4'd7, 2'b10);
    drive_w(1, 1, 2'b11);
    step();
    drive_aw(0, 4'd0, 2'b00);
    drive_w(0, 0, 2'b00);
    step();
    drive_w(1, 1, 2'b11);
    step();

    drive_w(0, 0, 2'b00);                     // fill, then force an AW while full
    for (int i = 0; i < DEPTH; i++) begin
      drive_aw(1, 4'(8 + i), 2'(1 << (i % 2)));
      step();
    end
    drive_aw(1, 4'd15, 2'b01);
    step();
    drive_aw(0, 4'd0, 2'b00);
    step();
    do_reset();
    step();

    drive_aw(1, 4'd4, 2'b00);                 // zero-hot target
    step();
    drive_aw(0, 4'd0, 2'b00);
    step();
    do_reset();

    drive_aw(1, 4'd9, 2'b01);                 // reset in the middle of a 4-beat burst
    step();
    drive_aw(0, 4'd0, 2'b00);
    for (int i = 0; i < 2; i++) begin
      drive_w(1, 0, 2'b11);
      step();
    end
    do_reset();
    drive_w(1, 0, 2'b11);
    step();
    drive_aw(1, 4'd10, 2'b10);
    drive_w(1, 1, 2'b10);
    step();
    drive_aw(0, 4'd0, 2'b00);
    drive_w(0, 0, 2'b00);
    step();

    for (int i = 0; i < 400; i++) begin
      bus.M_AWVALID = 1'($urandom_range(0, 1));
      bus.M_AWREADY = ($urandom_range(0, 2) != 0) && (q.size() < DEPTH);
      bus.M_AWID    = 4'($urandom_range(0, 15));
      bus.M_AWSEL   = $urandom_range(0, 1) ? 2'b01 : 2'b10;
      drive_w($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
